// File: rtl/traffic_control_pkg.sv
// Shared types and constants for the four-way traffic light controller.
package traffic_control_pkg;

  typedef enum logic [2:0] {
    N_GREEN  = 3'd0,
    N_YELLOW = 3'd1,
    S_GREEN  = 3'd2,
    S_YELLOW = 3'd3,
    E_GREEN  = 3'd4,
    E_YELLOW = 3'd5,
    W_GREEN  = 3'd6,
    W_YELLOW = 3'd7
  } tc_state_e;

  // Signal head encoding {red, yellow, green}
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  localparam logic [4:0] YELLOW_CYCLES = 5'd4;
  localparam logic [3:0] YELLOW_LAST   = 4'(YELLOW_CYCLES - 5'd1);

  // Green time grows in steps of four cycles with traffic density
  function automatic logic [4:0] green_duration(input logic [1:0] density);
    logic [4:0] dur;
    case (density)
      2'b00:   dur = 5'd4;
      2'b01:   dur = 5'd8;
      2'b10:   dur = 5'd12;
      2'b11:   dur = 5'd16;
      default: dur = 5'd4;
    endcase
    return dur;
  endfunction

  // Last counter value of a green phase (duration minus one fits in 4 bits)
  function automatic logic [3:0] green_last_count(input logic [1:0] density);
    logic [4:0] dur;
    dur = green_duration(density);
    return 4'(dur - 5'd1);
  endfunction

endpackage

// File: rtl/tc_phase_timer.sv
// Phase timer: counts cycles spent in the current light phase and flags
// the last cycle of the phase. The count restarts on the same edge that
// the controller moves to its next state.
module tc_phase_timer
  import traffic_control_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       green_phase,
  input  logic [1:0] density,
  output logic       done
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic [3:0] green_last;

  // Terminal-count compare; green uses the live density so it can stretch or cut short
  always_comb begin
    green_last = green_last_count(density);
    if (green_phase) begin
      done = (cnt_q >= green_last);
    end else begin
      done = (cnt_q == YELLOW_LAST);
    end
  end

  // Next count: restart on phase end, otherwise increment and hold at 15
  always_comb begin
    if (done) begin
      cnt_d = 4'd0;
    end else if (cnt_q == 4'd15) begin
      cnt_d = 4'd15;
    end else begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/traffic_control.sv
// Four-way traffic light controller: fixed round-robin N->S->E->W with
// density-dependent green time and fixed yellow time. Only the active
// direction is ever non-RED.
module traffic_control
  import traffic_control_pkg::*;
(
  input  logic       clk,
  input  logic       rst_a,
  input  logic [1:0] traffic_n,
  input  logic [1:0] traffic_s,
  input  logic [1:0] traffic_e,
  input  logic [1:0] traffic_w,
  output logic [2:0] n_lights,
  output logic [2:0] s_lights,
  output logic [2:0] e_lights,
  output logic [2:0] w_lights
);

  tc_state_e  state_q;
  tc_state_e  state_d;
  logic [1:0] active_density;
  logic       green_phase;
  logic       phase_done;

  // Route the active direction's density to the timer; other densities are ignored
  always_comb begin
    active_density = traffic_n;
    green_phase    = 1'b1;
    case (state_q)
      N_GREEN:  begin active_density = traffic_n; green_phase = 1'b1; end
      N_YELLOW: begin active_density = traffic_n; green_phase = 1'b0; end
      S_GREEN:  begin active_density = traffic_s; green_phase = 1'b1; end
      S_YELLOW: begin active_density = traffic_s; green_phase = 1'b0; end
      E_GREEN:  begin active_density = traffic_e; green_phase = 1'b1; end
      E_YELLOW: begin active_density = traffic_e; green_phase = 1'b0; end
      W_GREEN:  begin active_density = traffic_w; green_phase = 1'b1; end
      W_YELLOW: begin active_density = traffic_w; green_phase = 1'b0; end
      default:  begin active_density = traffic_n; green_phase = 1'b1; end
    endcase
  end

  tc_phase_timer u_timer (
    .clk         (clk),
    .rst         (rst_a),
    .green_phase (green_phase),
    .density     (active_density),
    .done        (phase_done)
  );

  // Round-robin next state, taken only on the last cycle of a phase
  always_comb begin
    state_d = state_q;
    if (phase_done) begin
      case (state_q)
        N_GREEN:  state_d = N_YELLOW;
        N_YELLOW: state_d = S_GREEN;
        S_GREEN:  state_d = S_YELLOW;
        S_YELLOW: state_d = E_GREEN;
        E_GREEN:  state_d = E_YELLOW;
        E_YELLOW: state_d = W_GREEN;
        W_GREEN:  state_d = W_YELLOW;
        W_YELLOW: state_d = N_GREEN;
        default:  state_d = N_GREEN;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State register; reset drops straight back to North green
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      state_q <= N_GREEN;
    end else begin
      state_q <= state_d;
    end
  end

  // Moore decode from the state register: one head GREEN/YELLOW, rest RED
  always_comb begin
    n_lights = RED;
    s_lights = RED;
    e_lights = RED;
    w_lights = RED;
    case (state_q)
      N_GREEN:  n_lights = GREEN;
      N_YELLOW: n_lights = YELLOW;
      S_GREEN:  s_lights = GREEN;
      S_YELLOW: s_lights = YELLOW;
      E_GREEN:  e_lights = GREEN;
      E_YELLOW: e_lights = YELLOW;
      W_GREEN:  w_lights = GREEN;
      W_YELLOW: w_lights = YELLOW;
      default:  n_lights = GREEN;
    endcase
  end

endmodule

// File: tb/tb_traffic_control.sv
// Self-checking bench for traffic_control. The reference model tracks the
// active direction, whether it is in yellow, and how many cycles the phase
// has lasted so far, and ends a phase once that length reaches the duration
// demanded by the live density.
module tb_traffic_control;

  logic       clk = 1'b0;
  logic       rst_a;
  logic [1:0] traffic_n, traffic_s, traffic_e, traffic_w;
  logic [2:0] n_lights, s_lights, e_lights, w_lights;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_dir;   // 0=N 1=S 2=E 3=W
  bit m_yel;
  int m_len;   // cycles spent in current phase, counting the present one

  traffic_control dut (
    .clk       (clk),
    .rst_a     (rst_a),
    .traffic_n (traffic_n),
    .traffic_s (traffic_s),
    .traffic_e (traffic_e),
    .traffic_w (traffic_w),
    .n_lights  (n_lights),
    .s_lights  (s_lights),
    .e_lights  (e_lights),
    .w_lights  (w_lights)
  );

  always #5 clk = ~clk;

  function automatic int dens_of(int d);
    case (d)
      0: return int'(traffic_n);
      1: return int'(traffic_s);
      2: return int'(traffic_e);
      default: return int'(traffic_w);
    endcase
  endfunction

  function automatic logic [2:0] exp_head(int d);
    if (d != m_dir) return 3'b100;
    return m_yel ? 3'b010 : 3'b001;
  endfunction

  function automatic logic [11:0] exp_all();
    return {exp_head(0), exp_head(1), exp_head(2), exp_head(3)};
  endfunction

  function automatic logic [11:0] got_all();
    return {n_lights, s_lights, e_lights, w_lights};
  endfunction

  task automatic model_reset();
    m_dir = 0;
    m_yel = 1'b0;
    m_len = 1;
  endtask

  // One clock: advance the model with the densities seen at the edge, then sit at negedge
  task automatic step();
    int limit;
    @(posedge clk);
    if (rst_a) begin
      model_reset();
    end else begin
      limit = m_yel ? 4 : 4 * (dens_of(m_dir) + 1);
      if (m_len >= limit) begin
        if (m_yel) begin
          m_dir = (m_dir + 1) % 4;
          m_yel = 1'b0;
        end else begin
          m_yel = 1'b1;
        end
        m_len = 1;
      end else begin
        m_len = m_len + 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_a = 1'b1;
    traffic_n = 2'b00; traffic_s = 2'b00; traffic_e = 2'b00; traffic_w = 2'b00;
    model_reset();
    #2;
    checks++;
    if (got_all() !== 12'b001_100_100_100) begin
      errors++;
      $display("FAIL reset_before_clock: got %b expected %b", got_all(), 12'b001_100_100_100);
    end
    step();
    step();
    checks++;
    if (got_all() !== 12'b001_100_100_100) begin
      errors++;
      $display("FAIL reset_held: got %b expected %b", got_all(), 12'b001_100_100_100);
    end
  endtask

  task automatic test_n_high();
    traffic_n = 2'b10;
    rst_a = 1'b0;
    model_reset();
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (n_lights !== 3'b001 || s_lights !== 3'b100) begin
        errors++;
        $display("FAIL n_green_cycle%0d: got n=%b s=%b expected n=001 s=100", i, n_lights, s_lights);
      end
      step();
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (n_lights !== 3'b010) begin
        errors++;
        $display("FAIL n_yellow_cycle%0d: got %b expected 010", i, n_lights);
      end
      step();
    end
    checks++;
    if (s_lights !== 3'b001 || n_lights !== 3'b100) begin
      errors++;
      $display("FAIL s_green_start: got n=%b s=%b expected n=100 s=001", n_lights, s_lights);
    end
  endtask

  task automatic test_round_robin();
    traffic_n = 2'b00; traffic_s = 2'b01; traffic_e = 2'b11; traffic_w = 2'b00;
    // S 8+4, E 16+4, W 4+4 = 40 cycles, then N green
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (got_all() !== exp_all()) begin
        errors++;
        $display("FAIL round_robin_cycle%0d: got %b expected %b", i, got_all(), exp_all());
      end
      step();
    end
    checks++;
    if (n_lights !== 3'b001 || w_lights !== 3'b100) begin
      errors++;
      $display("FAIL n_green_again: got n=%b w=%b expected n=001 w=100", n_lights, w_lights);
    end
  endtask

  task automatic test_density_drop();
    rst_a = 1'b1;
    traffic_n = 2'b11;
    step();
    rst_a = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (n_lights !== 3'b001) begin
      errors++;
      $display("FAIL drop_still_green: got %b expected 001", n_lights);
    end
    traffic_n = 2'b00;
    step();
    checks++;
    if (n_lights !== 3'b010) begin
      errors++;
      $display("FAIL drop_to_yellow: got %b expected 010", n_lights);
    end
  endtask

  task automatic test_extend();
    rst_a = 1'b1;
    traffic_n = 2'b00;
    step();
    rst_a = 1'b0;
    model_reset();
    step();
    step();
    traffic_n = 2'b11;
    for (int i = 2; i < 16; i++) begin
      checks++;
      if (n_lights !== 3'b001) begin
        errors++;
        $display("FAIL extend_green_cycle%0d: got %b expected 001", i, n_lights);
      end
      step();
    end
    checks++;
    if (n_lights !== 3'b010) begin
      errors++;
      $display("FAIL extend_end_yellow: got %b expected 010", n_lights);
    end
  endtask

  task automatic test_reset_mid();
    int budget;
    traffic_n = 2'($urandom_range(0, 3));
    traffic_s = 2'($urandom_range(0, 3));
    traffic_e = 2'($urandom_range(0, 3));
    traffic_w = 2'($urandom_range(0, 3));
    budget = 0;
    while (!(m_dir == 2 && m_yel && m_len == 2) && budget < 300) begin
      step();
      budget++;
    end
    checks++;
    if (budget >= 300) begin
      errors++;
      $display("FAIL reach_e_yellow: got timeout after %0d cycles expected E_YELLOW", budget);
    end else if (got_all() !== 12'b100_100_010_100) begin
      errors++;
      $display("FAIL e_yellow_before_reset: got %b expected %b", got_all(), 12'b100_100_010_100);
    end
    #2;
    rst_a = 1'b1;
    #1;
    checks++;
    if (got_all() !== 12'b001_100_100_100) begin
      errors++;
      $display("FAIL async_reset_mid: got %b expected %b", got_all(), 12'b001_100_100_100);
    end
    model_reset();
    step();
    traffic_n = 2'b01;
    rst_a = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (n_lights !== 3'b001) begin
        errors++;
        $display("FAIL post_reset_green_cycle%0d: got %b expected 001", i, n_lights);
      end
      step();
    end
    checks++;
    if (n_lights !== 3'b010) begin
      errors++;
      $display("FAIL post_reset_yellow: got %b expected 010", n_lights);
    end
  endtask

  task automatic test_random();
    int non_red;
    bit bad_code;
    logic [2:0] h [4];
    for (int c = 0; c < 600; c++) begin
      traffic_n = 2'($urandom_range(0, 3));
      traffic_s = 2'($urandom_range(0, 3));
      traffic_e = 2'($urandom_range(0, 3));
      traffic_w = 2'($urandom_range(0, 3));
      step();
      h[0] = n_lights; h[1] = s_lights; h[2] = e_lights; h[3] = w_lights;
      non_red  = 0;
      bad_code = 1'b0;
      for (int d = 0; d < 4; d++) begin
        if (h[d] !== 3'b100) non_red++;
        if (h[d] !== 3'b100 && h[d] !== 3'b010 && h[d] !== 3'b001) bad_code = 1'b1;
      end
      checks++;
      if (non_red != 1 || bad_code) begin
        errors++;
        $display("FAIL random_safety_cycle%0d: got %b non_red=%0d expected one legal non-RED head", c, got_all(), non_red);
      end
      checks++;
      if (got_all() !== exp_all()) begin
        errors++;
        $display("FAIL random_model_cycle%0d: got %b expected %b", c, got_all(), exp_all());
      end
    end
  endtask

  initial begin
    test_reset();
    test_n_high();
    test_round_robin();
    test_density_drop();
    test_extend();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_control.md
TRAFFIC_CONTROL -- requirements
Module: traffic_control

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst_a  input  1  reset; asynchronous, active-high.
REQ-003 traffic_n  input  2  North density: 00 low, 01 medium, 10 high, 11 very high.
REQ-004 traffic_s  input  2  South density, same encoding.
REQ-005 traffic_e  input  2  East density, same encoding.
REQ-006 traffic_w  input  2  West density, same encoding.
REQ-007 n_lights  output  3  North signal head, {red, yellow, green}, one-hot.
REQ-008 s_lights  output  3  South signal head, same encoding.
REQ-009 e_lights  output  3  East signal head, same encoding.
REQ-010 w_lights  output  3  West signal head, same encoding.

Function
REQ-011 Encodings SHALL be: RED=3'b100, YELLOW=3'b010, GREEN=3'b001; no other output value ever driven.
REQ-012 FSM SHALL have 8 states: N_GREEN, N_YELLOW, S_GREEN, S_YELLOW, E_GREEN, E_YELLOW, W_GREEN, W_YELLOW.
REQ-013 Sequence SHALL be fixed round-robin: N_GREEN->N_YELLOW->S_GREEN->S_YELLOW->E_GREEN->E_YELLOW->W_GREEN->W_YELLOW->N_GREEN.
REQ-014 Outputs SHALL be Moore, decoded combinationally from state register only: active direction GREEN or YELLOW, other three RED.
REQ-015 Green duration SHALL be 4/8/12/16 cycles for density 00/01/10/11 of the active direction.
REQ-016 Yellow duration SHALL be fixed at 4 cycles regardless of density.
REQ-017 A 4-bit phase counter SHALL clear to 0 on every state transition and increment each cycle otherwise.
REQ-018 Green phase SHALL end (transition at next edge) when counter >= green_duration-1, using the live density input of the active direction each cycle.
REQ-019 Density rising mid-green SHALL extend the phase to the new duration; falling below elapsed count SHALL end green at the next edge.
REQ-020 Yellow phase SHALL end when counter == 3.
REQ-021 Density inputs of non-active directions SHALL have no effect.
REQ-022 No two directions SHALL ever be non-RED simultaneously.
REQ-023 Counter SHALL never wrap; max value reached is 15.

Reset
REQ-024 rst_a high SHALL immediately force state=N_GREEN, counter=0, independent of clk.
REQ-025 During and right after reset outputs SHALL be n_lights=001, s/e/w_lights=100.
REQ-026 Reset asserted mid-phase SHALL abandon the phase; first green after release timed by traffic_n from counter 0.

Structure
REQ-027 Shared package traffic_control_pkg SHALL hold the state enum, light encodings RED/YELLOW/GREEN, YELLOW_CYCLES=4 and the density-to-green-duration function.
REQ-028 One sub-module tc_phase_timer (counter + terminal-count compare) SHALL be instantiated; FSM and output decode stay in traffic_control.

Verification
REQ-029 Reset with all densities 00 -> n=001, s=e=w=100 before any clock edge.
REQ-030 Release reset, traffic_n=10 -> N green 12 cycles, N yellow 4 cycles, then s_lights=001.
REQ-031 traffic_s=01, traffic_e=11, traffic_w=00 -> S green 8, E green 16, W green 4, each followed by 4 yellow, then N green again.
REQ-032 In N_GREEN with traffic_n=11, drop to 00 at cycle 6 -> N_YELLOW at next edge.
REQ-033 Assert rst_a mid E_YELLOW -> immediate return to N_GREEN, counter 0, outputs per REQ-025.
REQ-034 Every cycle of a 600-cycle random-density run -> exactly one non-RED head, all values one-hot.
